// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - opcodes, FSM states and width defaults for the SPI command sequencer
package spi_pkg;

  localparam int SPI_ADDR_W = 7;
  localparam int SPI_DATA_W = 8;

  localparam logic [7:0] OP_WRITE       = 8'h01;
  localparam logic [7:0] OP_READ        = 8'h02;
  localparam logic [7:0] OP_SET_CLK_DIV = 8'h03;
  localparam logic [7:0] OP_SET_SPIKE   = 8'h04;
  localparam logic [7:0] OP_SET_DEBUG   = 8'h05;
  localparam logic [7:0] OP_CLR_FLAGS   = 8'h06;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_MSB,
    ADDR_LSB,
    WR_DATA,
    RD_DATA,
    DRAIN
  } state_t;

endpackage

// File: rtl/spi_addr_counter.sv
// rtl/spi_addr_counter.sv - configuration-memory address pointer with load and wrapping increment
module spi_addr_counter #(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] count
);

  // Natural binary overflow gives the wrap from the top address back to zero.
  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (inc)
      count <= count + ADDR_W'(1);
  end

endmodule

// File: rtl/spi_cmd_sequencer.sv
// rtl/spi_cmd_sequencer.sv - decodes SPI command bytes into config-memory writes/reads and ready flags
module spi_cmd_sequencer
  import spi_pkg::*;
#(
  parameter int ADDR_W = SPI_ADDR_W,
  parameter int DATA_W = SPI_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] rx_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic              clk_div_ready,
  output logic              input_spike_ready,
  output logic              debug_config_ready,
  output logic              busy,
  output logic              cmd_error
);

  state_t state;
  logic   is_read;
  logic   cs_q;
  logic   take;
  logic   ptr_load;
  logic   ptr_inc;

  // A byte landing on the cycle cs rises is still honoured; later bytes with cs high are not.
  assign take     = data_valid && (!cs || !cs_q);
  assign ptr_load = take && (state == ADDR_LSB);
  assign ptr_inc  = mem_we || (take && (state == RD_DATA));
  assign busy     = (state != IDLE);

  spi_addr_counter #(
    .ADDR_W(ADDR_W)
  ) u_addr_counter (
    .clk     (clk),
    .reset   (reset),
    .load    (ptr_load),
    .inc     (ptr_inc),
    .load_val(rx_data[ADDR_W-1:0]),
    .count   (mem_addr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      is_read            <= 1'b0;
      cs_q               <= 1'b1;
      mem_wdata          <= '0;
      mem_we             <= 1'b0;
      mem_re             <= 1'b0;
      clk_div_ready      <= 1'b0;
      input_spike_ready  <= 1'b0;
      debug_config_ready <= 1'b0;
      cmd_error          <= 1'b0;
    end else begin
      cs_q      <= cs;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      cmd_error <= 1'b0;
      if (take) begin
        case (state)
          IDLE: begin
            case (rx_data)
              DATA_W'(OP_WRITE): begin
                is_read <= 1'b0;
                state   <= ADDR_MSB;
              end
              DATA_W'(OP_READ): begin
                is_read <= 1'b1;
                state   <= ADDR_MSB;
              end
              DATA_W'(OP_SET_CLK_DIV): begin
                clk_div_ready <= 1'b1;
                state         <= DRAIN;
              end
              DATA_W'(OP_SET_SPIKE): begin
                input_spike_ready <= 1'b1;
                state             <= DRAIN;
              end
              DATA_W'(OP_SET_DEBUG): begin
                debug_config_ready <= 1'b1;
                state              <= DRAIN;
              end
              DATA_W'(OP_CLR_FLAGS): begin
                clk_div_ready      <= 1'b0;
                input_spike_ready  <= 1'b0;
                debug_config_ready <= 1'b0;
                state              <= DRAIN;
              end
              default: begin
                cmd_error <= 1'b1;
                state     <= DRAIN;
              end
            endcase
          end
          ADDR_MSB: begin
            if (rx_data == '0) begin
              state <= ADDR_LSB;
            end else begin
              cmd_error <= 1'b1;
              state     <= DRAIN;
            end
          end
          ADDR_LSB: begin
            // Address bits above the memory size are rejected.
            if (rx_data[DATA_W-1:ADDR_W] != '0) begin
              cmd_error <= 1'b1;
              state     <= DRAIN;
            end else if (is_read) begin
              mem_re <= 1'b1;
              state  <= RD_DATA;
            end else begin
              state <= WR_DATA;
            end
          end
          WR_DATA: begin
            mem_wdata <= rx_data;
            mem_we    <= 1'b1;
          end
          RD_DATA: begin
            mem_re <= 1'b1;
          end
          DRAIN: begin
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
      if (cs)
        state <= IDLE;
    end
  end

endmodule
